// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: default 640x480@60 Hz porch/sync widths and coordinate width.
// No logic; consumed at elaboration only.
// Not applicable (constants only).
package vga_timing_pkg;
    localparam int COORD_W       = 10;
    localparam int MAX_TOTAL     = 1 << COORD_W;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL   = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL   = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrap counter with enable, decodes sync/active window from the NEXT count.
// Outputs are combinational from the count register and en; the parent registers them.
// No backpressure; en simply freezes the count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = DEF_H_TOTAL,
    parameter int SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT,
    parameter int SYNC_END   = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC,
    parameter int DISPLAY    = DEF_H_DISPLAY
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic [COORD_W-1:0] next_cnt,
    output logic               wrap,
    output logic               sync,
    output logic               active
);
    localparam logic [COORD_W-1:0] LAST   = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] SYNC_S = COORD_W'(SYNC_START);
    localparam logic [COORD_W-1:0] SYNC_E = COORD_W'(SYNC_END);
    localparam logic [COORD_W-1:0] DISP   = COORD_W'(DISPLAY);

    logic [COORD_W-1:0] cnt;

    // Next count and window decode, so the parent's registers line up with the new coordinate.
    always_comb begin
        wrap     = en && (cnt == LAST);
        next_cnt = cnt;
        if (wrap) begin
            next_cnt = '0;
        end else if (en) begin
            next_cnt = cnt + 1'b1;
        end
        sync   = (next_cnt >= SYNC_S) && (next_cnt < SYNC_E);
        active = (next_cnt < DISP);
    end

    // Count register; resets to the last position so the first enabled edge lands on 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= LAST;
        end else begin
            cnt <= next_cnt;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel timing: registered hsync/vsync, display_on, coordinates, line/frame strobes, frame index.
// Outputs change one clk after a pix_ce edge and all describe the same pixel.
// pix_ce=0 freezes timing and drops the strobes; no other flow control.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int SYNC_POL  = 0,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_ce,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [COORD_W-1:0] hpos,
    output logic [COORD_W-1:0] vpos,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);
    localparam int   H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int   V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam logic SYNC_ACT = (SYNC_POL != 0);

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed coordinate range");
        end
    endgenerate

    logic [COORD_W-1:0] h_next, v_next;
    logic               h_wrap, v_wrap;
    logic               h_sync, v_sync;
    logic               h_active, v_active;
    logic               v_en;

    assign v_en = pix_ce & h_wrap;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_DISPLAY + H_FRONT),
        .SYNC_END   (H_DISPLAY + H_FRONT + H_SYNC),
        .DISPLAY    (H_DISPLAY)
    ) u_h_ctr (
        .clk      (clk),
        .reset    (reset),
        .en       (pix_ce),
        .next_cnt (h_next),
        .wrap     (h_wrap),
        .sync     (h_sync),
        .active   (h_active)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_DISPLAY + V_FRONT),
        .SYNC_END   (V_DISPLAY + V_FRONT + V_SYNC),
        .DISPLAY    (V_DISPLAY)
    ) u_v_ctr (
        .clk      (clk),
        .reset    (reset),
        .en       (v_en),
        .next_cnt (v_next),
        .wrap     (v_wrap),
        .sync     (v_sync),
        .active   (v_active)
    );

    // Output registers; v_wrap only fires together with h_wrap, so it marks the wrap to (0,0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos        <= COORD_W'(H_TOTAL - 1);
            vpos        <= COORD_W'(V_TOTAL - 1);
            hsync       <= ~SYNC_ACT;
            vsync       <= ~SYNC_ACT;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '1;
        end else begin
            hpos        <= h_next;
            vpos        <= v_next;
            hsync       <= h_sync ? SYNC_ACT : ~SYNC_ACT;
            vsync       <= v_sync ? SYNC_ACT : ~SYNC_ACT;
            display_on  <= h_active && v_active;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            if (v_wrap) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance for line-level checks, small-timing instance
// (active-high sync, FRAME_W=2) for frame-level checks, both against an arithmetic position model.
module tb_vga_timing_gen;
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       disp;
        logic [9:0] h;
        logic [9:0] v;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    typedef struct {
        logic rst;
        logic ce;
        obs_t exp;
    } vec_t;

    localparam int S_HD = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VD = 6, S_VF = 1, S_VS = 2, S_VB = 2;
    localparam int S_FT = (S_HD + S_HF + S_HS + S_HB) * (S_VD + S_VF + S_VS + S_VB);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_d, ce_d, hs_d, vs_d, disp_d, ls_d, fs_d;
    logic [9:0] hpos_d, vpos_d;
    logic [7:0] fc_d;
    logic       rst_s, ce_s, hs_s, vs_s, disp_s, ls_s, fs_s;
    logic [9:0] hpos_s, vpos_s;
    logic [1:0] fc_s;

    int checks = 0;
    int errors = 0;
    int t_d = 0, t_s = 0;
    bit le_d = 0, le_s = 0;

    vga_timing_gen dut_d (
        .clk(clk), .reset(rst_d), .pix_ce(ce_d), .hsync(hs_d), .vsync(vs_d),
        .display_on(disp_d), .hpos(hpos_d), .vpos(vpos_d), .line_start(ls_d),
        .frame_start(fs_d), .frame_count(fc_d)
    );

    vga_timing_gen #(
        .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .SYNC_POL(1), .FRAME_W(2)
    ) dut_s (
        .clk(clk), .reset(rst_s), .pix_ce(ce_s), .hsync(hs_s), .vsync(vs_s),
        .display_on(disp_s), .hpos(hpos_s), .vpos(vpos_s), .line_start(ls_s),
        .frame_start(fs_s), .frame_count(fc_s)
    );

    function automatic obs_t mk(int h, int v, bit hs, bit vs, bit disp, bit ls, bit fs, int fc);
        obs_t o;
        o.h = 10'(h); o.v = 10'(v); o.hs = hs; o.vs = vs; o.disp = disp;
        o.ls = ls; o.fs = fs; o.fc = 8'(fc);
        return o;
    endfunction

    // t = number of enabled edges since reset; le = whether the latest edge was enabled.
    function automatic obs_t model(int t, bit le, int hd, int hf, int hsw, int hb,
                                   int vd, int vf, int vsw, int vb, bit pol, int fw);
        int ht, vt, idx, h, v;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        if (t == 0) return mk(ht - 1, vt - 1, ~pol, ~pol, 1'b0, 1'b0, 1'b0, (1 << fw) - 1);
        idx = (t - 1) % (ht * vt);
        h = idx % ht;
        v = idx / ht;
        return mk(h, v,
                  (h >= hd + hf && h < hd + hf + hsw) ? pol : ~pol,
                  (v >= vd + vf && v < vd + vf + vsw) ? pol : ~pol,
                  (h < hd) && (v < vd), le && (h == 0), le && (idx == 0),
                  ((t - 1) / (ht * vt)) % (1 << fw));
    endfunction

    function automatic obs_t obs_d();
        return mk(int'(hpos_d), int'(vpos_d), hs_d, vs_d, disp_d, ls_d, fs_d, int'(fc_d));
    endfunction

    function automatic obs_t obs_s();
        return mk(int'(hpos_s), int'(vpos_s), hs_s, vs_s, disp_s, ls_s, fs_s, int'(fc_s));
    endfunction

    task automatic cmp(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d | exp h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                     name, got.h, got.v, got.hs, got.vs, got.disp, got.ls, got.fs, got.fc,
                     exp.h, exp.v, exp.hs, exp.vs, exp.disp, exp.ls, exp.fs, exp.fc);
        end
    endtask

    task automatic cmp_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic check_d(input string name);
        cmp(name, obs_d(), model(t_d, le_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 8));
    endtask

    task automatic check_s(input string name);
        cmp(name, obs_s(), model(t_s, le_s, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB, 1'b1, 2));
    endtask

    // Drive at the negedge, let one posedge act, sample at the next negedge.
    task automatic tick_d(input logic ce, input string name);
        ce_d = ce;
        @(posedge clk);
        if (!rst_d) begin
            if (ce) t_d++;
            le_d = ce;
        end
        @(negedge clk);
        check_d(name);
    endtask

    task automatic tick_s(input logic ce, input string name);
        ce_s = ce;
        @(posedge clk);
        if (!rst_s) begin
            if (ce) t_s++;
            le_s = ce;
        end
        @(negedge clk);
        check_s(name);
    endtask

    vec_t tbl[7];

    initial begin
        int hs_low, fall_h, vs_act, hs_act;
        int q_fc[$];
        int q_n[$];
        obs_t snap;

        rst_d = 1'b1; ce_d = 1'b1; rst_s = 1'b1; ce_s = 1'b0;

        // Reset for 3 clk, release with pix_ce=1, then a held edge and two steps.
        tbl[0] = '{1'b1, 1'b1, mk(799, 524, 1, 1, 0, 0, 0, 255)};
        tbl[1] = '{1'b1, 1'b1, mk(799, 524, 1, 1, 0, 0, 0, 255)};
        tbl[2] = '{1'b1, 1'b1, mk(799, 524, 1, 1, 0, 0, 0, 255)};
        tbl[3] = '{1'b0, 1'b1, mk(0, 0, 1, 1, 1, 1, 1, 0)};
        tbl[4] = '{1'b0, 1'b0, mk(0, 0, 1, 1, 1, 0, 0, 0)};
        tbl[5] = '{1'b0, 1'b1, mk(1, 0, 1, 1, 1, 0, 0, 0)};
        tbl[6] = '{1'b0, 1'b1, mk(2, 0, 1, 1, 1, 0, 0, 0)};

        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            rst_d = tbl[i].rst;
            ce_d  = tbl[i].ce;
            @(posedge clk);
            @(negedge clk);
            cmp($sformatf("vec%0d", i), obs_d(), tbl[i].exp);
        end

        // Fresh reset, then one full line plus one edge with pix_ce=1.
        rst_d = 1'b1; t_d = 0; le_d = 0;
        tick_d(1'b1, "rst_d");
        rst_d = 1'b0;
        hs_low = 0; fall_h = -1;
        for (int n = 1; n <= 801; n++) begin
            tick_d(1'b1, "line_d");
            if (n <= 800 && hs_d == 1'b0) hs_low++;
            if (fall_h < 0 && n > 1 && disp_d == 1'b0) fall_h = int'(hpos_d);
        end
        cmp_int("hsync_low_cycles", hs_low, 96);
        cmp_int("display_fall_h", fall_h, 640);
        cmp_int("line2_ls", int'(ls_d), 1);
        cmp_int("line2_vpos", int'(vpos_d), 1);
        cmp_int("line2_fs", int'(fs_d), 0);

        // Advance to hpos=700 on line 1, then reset between clock edges.
        for (int n = 0; n < 700; n++) tick_d(1'b1, "run_d");
        cmp_int("h700", int'(hpos_d), 700);
        cmp_int("h700_hsync", int'(hs_d), 0);
        #2;
        rst_d = 1'b1; t_d = 0; le_d = 0;
        #1;
        cmp("arst_d", obs_d(), mk(799, 524, 1, 1, 0, 0, 0, 255));
        tick_d(1'b1, "rst_hold_d");
        rst_d = 1'b0;

        // Random pix_ce on the default instance.
        for (int n = 0; n < 2000; n++) tick_d(($urandom_range(0, 3) != 0), "rand_d");
        rst_d = 1'b1; ce_d = 1'b0;

        // Small instance: five frame_starts, checking frame index and spacing.
        tick_s(1'b1, "rst_s");
        rst_s = 1'b0;
        vs_act = 0; hs_act = 0;
        for (int n = 1; n <= 4 * S_FT + 1; n++) begin
            tick_s(1'b1, "frames_s");
            if (n <= S_FT && vs_s == 1'b1) vs_act++;
            if (n <= 15 && hs_s == 1'b1) hs_act++;
            if (fs_s) begin
                q_fc.push_back(int'(fc_s));
                q_n.push_back(n);
            end
        end
        cmp_int("vsync_act_cycles", vs_act, 30);
        cmp_int("hsync_act_cycles", hs_act, 3);
        cmp_int("frame_start_count", q_fc.size(), 5);
        for (int i = 0; i < q_fc.size(); i++) begin
            cmp_int($sformatf("fc_seq%0d", i), q_fc[i], i % 4);
            if (i > 0) cmp_int($sformatf("fs_gap%0d", i), q_n[i] - q_n[i-1], S_FT);
        end

        // Park at the last pixel of the frame, freeze for 5 clk, then resume.
        for (int n = 0; n < S_FT - 1; n++) tick_s(1'b1, "park_s");
        cmp_int("park_h", int'(hpos_s), 14);
        cmp_int("park_v", int'(vpos_s), 10);
        snap = obs_s();
        for (int n = 0; n < 5; n++) begin
            tick_s(1'b0, "freeze_model");
            cmp($sformatf("freeze%0d", n), obs_s(), snap);
        end
        tick_s(1'b1, "resume_s");
        cmp("resume", obs_s(), mk(0, 0, 0, 0, 1, 1, 1, 1));

        // Random pix_ce with occasional asynchronous resets on the small instance.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst_s = 1'b1; t_s = 0; le_s = 0;
                #1;
                check_s("arst_s");
                tick_s(1'b1, "rst_hold_s");
                rst_s = 1'b0;
            end
            tick_s(($urandom_range(0, 3) != 0), "rand_s");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
